// File: rtl/icache_if.sv
// Fetch-side and refill-side handshake bundle for the icache.
// The slave modport is the cache, the master modport is the fetcher plus memory unit.
interface icache_if;
  logic        rdy;
  logic        clear;
  logic        fetch_ena;
  logic [31:0] fetch_addr;
  logic        fetch_ok;
  logic [31:0] fetch_inst;
  logic        mem_ena;
  logic [31:0] mem_addr;
  logic        mem_ok;
  logic [31:0] mem_data;

  modport slave (
    input  rdy, clear, fetch_ena, fetch_addr, mem_ok, mem_data,
    output fetch_ok, fetch_inst, mem_ena, mem_addr
  );

  modport master (
    output rdy, clear, fetch_ena, fetch_addr, mem_ok, mem_data,
    input  fetch_ok, fetch_inst, mem_ena, mem_addr
  );
endinterface

// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache with a blocking IDLE/MISS refill FSM.
// Define ICACHE_STAT_EN to add hit_count/miss_count statistics outputs.
module icache #(
  parameter int INDEX_WIDTH = 6
) (
  input  logic        clk,
  input  logic        rst,
  icache_if.slave     bus
`ifdef ICACHE_STAT_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);
  localparam int LINES = 1 << INDEX_WIDTH;
  localparam int TAG_W = 16 - INDEX_WIDTH;

  typedef enum logic {IDLE, MISS} state_e;

  state_e                  state_q;
  logic                    fetch_ok_q;
  logic [31:0]             fetch_inst_q;
  logic                    mem_ena_q;
  logic [15:0]             word_q;
  logic [LINES-1:0]        valid_q;
  logic [TAG_W-1:0]        tag_q  [LINES];
  logic [31:0]             data_q [LINES];

  logic [15:0]             req_word;
  logic [INDEX_WIDTH-1:0]  req_idx;
  logic [TAG_W-1:0]        req_tag;
  logic [INDEX_WIDTH-1:0]  fill_idx;
  logic [TAG_W-1:0]        fill_tag;
  logic                    hit;
  logic                    accept;
  logic                    fill;
  logic                    unused_addr;

  assign req_word    = bus.fetch_addr[17:2];
  assign req_idx     = req_word[INDEX_WIDTH-1:0];
  assign req_tag     = req_word[15:INDEX_WIDTH];
  assign fill_idx    = word_q[INDEX_WIDTH-1:0];
  assign fill_tag    = word_q[15:INDEX_WIDTH];
  assign unused_addr = ^{bus.fetch_addr[31:18], bus.fetch_addr[1:0]};

  assign hit    = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  // A request is only looked at when idle, unflushed and not in the delivery cycle.
  assign accept = bus.rdy && !bus.clear && (state_q == IDLE) && bus.fetch_ena && !fetch_ok_q;
  // Refill data lands even when a flush arrives on the same edge.
  assign fill   = bus.rdy && (state_q == MISS) && bus.mem_ok;

  assign bus.fetch_ok   = fetch_ok_q;
  assign bus.fetch_inst = fetch_inst_q;
  assign bus.mem_ena    = mem_ena_q;
  assign bus.mem_addr   = {14'b0, word_q, 2'b00};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      fetch_ok_q   <= 1'b0;
      fetch_inst_q <= '0;
      mem_ena_q    <= 1'b0;
      word_q       <= '0;
      valid_q      <= '0;
    end else if (bus.rdy) begin
      if (fill) valid_q[fill_idx] <= 1'b1;
      if (bus.clear) begin
        state_q    <= IDLE;
        fetch_ok_q <= 1'b0;
        mem_ena_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            fetch_ok_q <= 1'b0;
            if (accept) begin
              if (hit) begin
                fetch_ok_q   <= 1'b1;
                fetch_inst_q <= data_q[req_idx];
              end else begin
                word_q    <= req_word;
                mem_ena_q <= 1'b1;
                state_q   <= MISS;
              end
            end
          end
          MISS: begin
            if (bus.mem_ok) begin
              mem_ena_q    <= 1'b0;
              fetch_ok_q   <= 1'b1;
              fetch_inst_q <= bus.mem_data;
              state_q      <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // Tags and data need no reset: valid bits alone gate hits.
  always_ff @(posedge clk) begin
    if (fill) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= bus.mem_data;
    end
  end

`ifdef ICACHE_STAT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (accept) begin
      if (hit) hit_count  <= hit_count + 32'd1;
      else     miss_count <= miss_count + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_icache.sv
// Directed-vector bench for icache: cold miss, hit, conflict, flush, stall and reset cases.
module tb_icache;
  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  icache_if bus ();

`ifdef ICACHE_STAT_EN
  logic [31:0] hit_count, miss_count;
  icache #(.INDEX_WIDTH(6)) u_dut (
    .clk(clk), .rst(rst), .bus(bus),
    .hit_count(hit_count), .miss_count(miss_count)
  );
`else
  icache #(.INDEX_WIDTH(6)) u_dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] addr);
    bus.fetch_ena  = 1'b1;
    bus.fetch_addr = addr;
    tick();
    bus.fetch_ena  = 1'b0;
  endtask

  task automatic refill(input logic [31:0] data);
    bus.mem_ok   = 1'b1;
    bus.mem_data = data;
    tick();
    bus.mem_ok   = 1'b0;
  endtask

  initial begin
    rst            = 1'b1;
    bus.rdy        = 1'b1;
    bus.clear      = 1'b0;
    bus.fetch_ena  = 1'b0;
    bus.fetch_addr = '0;
    bus.mem_ok     = 1'b0;
    bus.mem_data   = '0;
    #12;
    chk("rst_ok",   {31'b0, bus.fetch_ok}, 32'd0);
    chk("rst_inst", bus.fetch_inst, 32'd0);
    chk("rst_mena", {31'b0, bus.mem_ena}, 32'd0);
    chk("rst_maddr", bus.mem_addr, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // cold miss at 0x0
    fetch(32'h0000_0000);
    chk("cold_mena", {31'b0, bus.mem_ena}, 32'd1);
    chk("cold_maddr", bus.mem_addr, 32'h0000_0000);
    chk("cold_ok0", {31'b0, bus.fetch_ok}, 32'd0);
    tick();
    tick();
    chk("cold_hold", {31'b0, bus.mem_ena}, 32'd1);
    refill(32'h0000_0013);
    chk("cold_ok", {31'b0, bus.fetch_ok}, 32'd1);
    chk("cold_inst", bus.fetch_inst, 32'h0000_0013);
    chk("cold_mdrop", {31'b0, bus.mem_ena}, 32'd0);
    tick();
    chk("cold_pulse", {31'b0, bus.fetch_ok}, 32'd0);

    // hit; request in the delivery cycle is ignored
    fetch(32'h0000_0000);
    chk("hit_ok", {31'b0, bus.fetch_ok}, 32'd1);
    chk("hit_inst", bus.fetch_inst, 32'h0000_0013);
    chk("hit_mena", {31'b0, bus.mem_ena}, 32'd0);
`ifdef ICACHE_STAT_EN
    chk("stat_hit", hit_count, 32'd1);
    chk("stat_miss", miss_count, 32'd1);
`endif
    fetch(32'h0000_0400);
    chk("ign_mena", {31'b0, bus.mem_ena}, 32'd0);
    chk("ign_ok", {31'b0, bus.fetch_ok}, 32'd0);

    // upper and lower address bits are ignored
    fetch(32'hFFFC_0003);
    chk("alias_ok", {31'b0, bus.fetch_ok}, 32'd1);
    chk("alias_inst", bus.fetch_inst, 32'h0000_0013);
    tick();

    // conflict on index 0
    fetch(32'h0000_0100);
    chk("conf_mena", {31'b0, bus.mem_ena}, 32'd1);
    chk("conf_maddr", bus.mem_addr, 32'h0000_0100);
    refill(32'h1111_1111);
    chk("conf_inst", bus.fetch_inst, 32'h1111_1111);
    tick();
    fetch(32'h0000_0000);
    chk("evict_mena", {31'b0, bus.mem_ena}, 32'd1);
    chk("evict_maddr", bus.mem_addr, 32'h0000_0000);
    refill(32'h0000_0013);
    tick();

    // clear mid-miss
    fetch(32'h0000_0040);
    chk("clr_mena1", {31'b0, bus.mem_ena}, 32'd1);
    chk("clr_maddr", bus.mem_addr, 32'h0000_0040);
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    chk("clr_mena0", {31'b0, bus.mem_ena}, 32'd0);
    chk("clr_ok0", {31'b0, bus.fetch_ok}, 32'd0);
    tick();
    fetch(32'h0000_0040);
    chk("clr2_mena", {31'b0, bus.mem_ena}, 32'd1);
    bus.clear = 1'b1;
    refill(32'hDEAD_BEEF);
    bus.clear = 1'b0;
    chk("clrok_ok", {31'b0, bus.fetch_ok}, 32'd0);
    chk("clrok_mena", {31'b0, bus.mem_ena}, 32'd0);
    tick();
    fetch(32'h0000_0040);
    chk("clrok_hit", {31'b0, bus.fetch_ok}, 32'd1);
    chk("clrok_inst", bus.fetch_inst, 32'hDEAD_BEEF);
    tick();

    // clear drops a simultaneous fetch
    bus.clear = 1'b1;
    fetch(32'h0000_0080);
    bus.clear = 1'b0;
    chk("clrf_mena", {31'b0, bus.mem_ena}, 32'd0);
    chk("clrf_ok", {31'b0, bus.fetch_ok}, 32'd0);

    // rdy stall during miss; mem_ok while stalled is lost
    fetch(32'h0000_0200);
    chk("stall_mena", {31'b0, bus.mem_ena}, 32'd1);
    bus.rdy = 1'b0;
    refill(32'h0000_0BAD);
    for (int i = 0; i < 4; i++) tick();
    chk("stall_hold", {31'b0, bus.mem_ena}, 32'd1);
    chk("stall_ok", {31'b0, bus.fetch_ok}, 32'd0);
    bus.rdy = 1'b1;
    tick();
    chk("stall_lost", {31'b0, bus.mem_ena}, 32'd1);
    refill(32'hCAFE_0001);
    chk("stall_fok", {31'b0, bus.fetch_ok}, 32'd1);
    chk("stall_inst", bus.fetch_inst, 32'hCAFE_0001);
    bus.rdy = 1'b0;
    tick();
    chk("stall_okhold", {31'b0, bus.fetch_ok}, 32'd1);
    bus.rdy = 1'b1;
    tick();
    chk("stall_okdrop", {31'b0, bus.fetch_ok}, 32'd0);

    // reset mid-miss
    fetch(32'h0000_0300);
    chk("rmiss_mena", {31'b0, bus.mem_ena}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rmiss_async", {31'b0, bus.mem_ena}, 32'd0);
    tick();
    rst = 1'b0;
    refill(32'h5555_5555);
    chk("rmiss_ignok", {31'b0, bus.fetch_ok}, 32'd0);
    fetch(32'h0000_0000);
    chk("rmiss_cold", {31'b0, bus.mem_ena}, 32'd1);
    chk("rmiss_nook", {31'b0, bus.fetch_ok}, 32'd0);
    refill(32'h0000_0013);
    chk("rmiss_inst", bus.fetch_inst, 32'h0000_0013);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
